// File: rtl/alimentador_instrucoes_pkg.sv
// Shared definitions for the instruction feeder: FSM state encoding and
// the instruction word width seen by the processor.
package alimentador_instrucoes_pkg;

  localparam int unsigned INSTR_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } estado_t;

endpackage

// File: rtl/alimentador_instrucoes_memoria.sv
// memoria_instrucoes: 2^ADDR_WIDTH x INSTR_WIDTH program RAM.
// Ports: clock; wr_en/wr_addr/wr_data synchronous write port;
//        rd_addr in, rd_data out (registered read, write-before-read).
module memoria_instrucoes
  import alimentador_instrucoes_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                   clock,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [INSTR_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [INSTR_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [INSTR_WIDTH-1:0] rd_data_d;
  logic [INSTR_WIDTH-1:0] rd_data_q;

  // Same-cycle write to the read address forwards the new word.
  always_comb begin
    rd_data_d = mem_q[rd_addr];
    if (wr_en && (wr_addr == rd_addr)) begin
      rd_data_d = wr_data;
    end
  end

  // Storage is never reset; contents survive a feeder reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/alimentador_instrucoes.sv
// alimentador_instrucoes: feeds a program, one 16-bit instruction at a time,
// to a processor; waits for its done pulse, aborts on a watchdog timeout.
// Inputs : clock, reset (sync, active-high), load_en/load_addr/load_data
//          (program load, IDLE only), start, last_addr, done.
// Outputs: iin, run, pc, busy, finished (pulse), timeout_err (sticky).
module alimentador_instrucoes
  import alimentador_instrucoes_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  last_addr,
  input  logic                   done,
  output logic [INSTR_WIDTH-1:0] iin,
  output logic                   run,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   busy,
  output logic                   finished,
  output logic                   timeout_err
);

  localparam int unsigned TIMER_WIDTH = $clog2(TIMEOUT + 1);

  estado_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  last_q, last_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  logic [INSTR_WIDTH-1:0] iin_q, iin_d;
  logic                   run_q, run_d;
  logic                   busy_q, busy_d;
  logic                   finished_q, finished_d;
  logic                   timeout_err_q, timeout_err_d;

  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   is_last;
  logic                   timer_full;

  assign mem_we     = load_en && (state_q == ST_IDLE);
  assign is_last    = (pc_q == last_q);
  assign timer_full = (timer_q == TIMER_WIDTH'(TIMEOUT));

  // Read address is the next pc, so the word is ready when FETCH ends.
  memoria_instrucoes #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_memoria (
    .clock   (clock),
    .wr_en   (mem_we),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .rd_addr (pc_d),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (done) begin
          state_d = is_last ? ST_IDLE : ST_FETCH;
        end else if (timer_full) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; done takes priority over the watchdog.
  always_comb begin
    pc_d          = pc_q;
    last_d        = last_q;
    timer_d       = timer_q;
    iin_d         = iin_q;
    timeout_err_d = timeout_err_q;
    finished_d    = 1'b0;
    run_d         = (state_d == ST_EXEC);
    busy_d        = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        iin_d = '0;
        if (start) begin
          pc_d          = '0;
          last_d        = last_addr;
          timeout_err_d = 1'b0;
        end
      end
      ST_FETCH: begin
        iin_d   = rd_data;
        timer_d = TIMER_WIDTH'(1);
      end
      ST_EXEC: begin
        if (done) begin
          if (is_last) begin
            finished_d = 1'b1;
            iin_d      = '0;
          end else begin
            pc_d = pc_q + ADDR_WIDTH'(1);
          end
        end else if (timer_full) begin
          timeout_err_d = 1'b1;
          iin_d         = '0;
        end else begin
          timer_d = timer_q + TIMER_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= '0;
      last_q        <= '0;
      timer_q       <= '0;
      iin_q         <= '0;
      run_q         <= 1'b0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      last_q        <= last_d;
      timer_q       <= timer_d;
      iin_q         <= iin_d;
      run_q         <= run_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign iin         = iin_q;
  assign run         = run_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_alimentador_instrucoes.sv
// Self-checking bench for alimentador_instrucoes: randomized runs compared
// against a program-level model (word sequence, EXEC lengths, end status).
module tb_alimentador_instrucoes;

  localparam int unsigned AW = 5;
  localparam int          TO = 15;
  localparam int          NW = 32;

  logic          clock = 1'b0;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          start;
  logic [AW-1:0] last_addr;
  logic          done;
  logic [15:0]   iin;
  logic          run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;
  logic          timeout_err;

  alimentador_instrucoes #(
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .start       (start),
    .last_addr   (last_addr),
    .done        (done),
    .iin         (iin),
    .run         (run),
    .pc          (pc),
    .busy        (busy),
    .finished    (finished),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Program-level reference: memory image and per-instruction done delay.
  logic [15:0] mem_model [NW];
  int          hold [NW];
  logic [15:0] exp_word [$];
  int          exp_len [$];
  bit          exp_timeout;
  logic [AW-1:0] exp_pc_end;

  // Observations from one run.
  logic [15:0] obs_word [$];
  int          obs_len [$];
  int          obs_gap [$];
  int          obs_unstable, obs_early_fin;
  bit          obs_hang;
  logic        obs_fin1, obs_fin2, obs_terr, obs_terr_start, obs_run_end;
  logic [15:0] obs_iin_end;
  logic [AW-1:0] obs_pc_end;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    mem_model[a] = d;
  endtask

  // Expected behaviour of one run from the program rules.
  task automatic model_run(input int last);
    exp_word.delete(); exp_len.delete(); exp_timeout = 0; exp_pc_end = '0;
    for (int k = 0; k <= last; k++) begin
      exp_word.push_back(mem_model[k]);
      exp_pc_end = AW'(k);
      if (hold[k] >= TO) begin
        exp_len.push_back(TO);
        exp_timeout = 1;
        break;
      end
      exp_len.push_back(hold[k] + 1);
    end
  endtask

  // Drives one run acting as the processor; noise on done/load_en outside EXEC.
  task automatic do_run(input logic [AW-1:0] last, input bit ld0, input logic [15:0] ld0_data);
    int gap, len, budget, k;
    bit in_exec;
    logic [15:0] w0;
    obs_word.delete(); obs_len.delete(); obs_gap.delete();
    obs_unstable = 0; obs_early_fin = 0; obs_hang = 0;
    last_addr = last; start = 1'b1;
    load_en = ld0; load_addr = '0; load_data = ld0_data;
    if (ld0) mem_model[0] = ld0_data;
    tick();
    start = 1'b0; load_en = 1'b0; last_addr = AW'($urandom);
    obs_terr_start = timeout_err;
    gap = 0; len = 0; in_exec = 0; budget = 4000; w0 = '0;
    while (busy) begin
      if (finished) obs_early_fin++;
      if (run) begin
        if (!in_exec) begin
          obs_gap.push_back(gap); obs_word.push_back(iin);
          in_exec = 1; len = 0; w0 = iin;
        end else if (iin !== w0) begin
          obs_unstable++;
        end
        len++;
        k = obs_word.size() - 1;
        done = (len == hold[k] + 1);
      end else begin
        if (in_exec) begin obs_len.push_back(len); in_exec = 0; gap = 0; end
        gap++;
        done = 1'($urandom_range(0, 1));
      end
      load_en = 1'($urandom_range(0, 1)); load_addr = AW'($urandom); load_data = 16'($urandom);
      tick();
      budget--;
      if (budget == 0) begin obs_hang = 1; break; end
    end
    if (in_exec) obs_len.push_back(len);
    done = 1'b0; load_en = 1'b0;
    obs_fin1 = finished; obs_terr = timeout_err; obs_iin_end = iin;
    obs_run_end = run; obs_pc_end = pc;
    tick();
    obs_fin2 = finished;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    total++; if (iin !== 16'h0) begin bad++; $display("FAIL reset_iin got %h exp 0000", iin); end
    total++; if (run !== 1'b0) begin bad++; $display("FAIL reset_run got %b exp 0", run); end
    total++; if (pc !== '0) begin bad++; $display("FAIL reset_pc got %0d exp 0", pc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b exp 0", busy); end
    total++; if (finished !== 1'b0) begin bad++; $display("FAIL reset_finished got %b exp 0", finished); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_word(0, 16'h1234); load_word(1, 16'h5678); load_word(2, 16'h9ABC);
    for (int i = 0; i < NW; i++) hold[i] = 2;
    model_run(2);
    do_run(2, 0, '0);
    total++; if (obs_word.size() != 3) begin bad++; $display("FAIL basic_count got %0d exp 3", obs_word.size()); end
    for (int i = 0; i < 3 && i < obs_word.size(); i++) begin
      total++; if (obs_word[i] !== exp_word[i]) begin bad++; $display("FAIL basic_word[%0d] got %h exp %h", i, obs_word[i], exp_word[i]); end
      total++; if (obs_len[i] != 3) begin bad++; $display("FAIL basic_len[%0d] got %0d exp 3", i, obs_len[i]); end
      total++; if (obs_gap[i] != 1) begin bad++; $display("FAIL basic_gap[%0d] got %0d exp 1", i, obs_gap[i]); end
    end
    total++; if (obs_unstable != 0) begin bad++; $display("FAIL basic_iin_stable got %0d changes exp 0", obs_unstable); end
    total++; if (obs_early_fin != 0) begin bad++; $display("FAIL basic_early_finished got %0d exp 0", obs_early_fin); end
    total++; if (obs_fin1 !== 1'b1 || obs_fin2 !== 1'b0) begin bad++; $display("FAIL basic_finished_pulse got %b%b exp 10", obs_fin1, obs_fin2); end
    total++; if (obs_iin_end !== 16'h0 || obs_run_end !== 1'b0) begin bad++; $display("FAIL basic_idle_out got iin=%h run=%b exp 0000/0", obs_iin_end, obs_run_end); end
    total++; if (obs_pc_end !== 5'd2) begin bad++; $display("FAIL basic_pc_end got %0d exp 2", obs_pc_end); end
    total++; if (obs_terr !== 1'b0 || obs_hang) begin bad++; $display("FAIL basic_status got terr=%b hang=%0d exp 0/0", obs_terr, obs_hang); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NW; i++) hold[i] = 100;
    model_run(2);
    do_run(2, 0, '0);
    total++; if (obs_len.size() != 1 || obs_len[0] != TO) begin bad++; $display("FAIL timeout_run_len got n=%0d len=%0d exp 1/%0d", obs_len.size(), (obs_len.size() > 0) ? obs_len[0] : -1, TO); end
    total++; if (obs_word.size() < 1 || obs_word[0] !== exp_word[0]) begin bad++; $display("FAIL timeout_word got n=%0d exp %h", obs_word.size(), exp_word[0]); end
    total++; if (obs_terr !== 1'b1) begin bad++; $display("FAIL timeout_err_set got %b exp 1", obs_terr); end
    total++; if (obs_iin_end !== 16'h0 || obs_fin1 !== 1'b0) begin bad++; $display("FAIL timeout_idle got iin=%h fin=%b exp 0000/0", obs_iin_end, obs_fin1); end
    total++; if (obs_pc_end !== exp_pc_end) begin bad++; $display("FAIL timeout_pc got %0d exp %0d", obs_pc_end, exp_pc_end); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky got %b exp 1", timeout_err); end
    for (int i = 0; i < NW; i++) hold[i] = 0;
    do_run(1, 0, '0);
    total++; if (obs_terr_start !== 1'b0) begin bad++; $display("FAIL timeout_clear_on_start got %b exp 0", obs_terr_start); end
    total++; if (obs_fin1 !== 1'b1 || obs_terr !== 1'b0) begin bad++; $display("FAIL timeout_rerun got fin=%b terr=%b exp 1/0", obs_fin1, obs_terr); end
  endtask

  task automatic test_done_at_limit();
    for (int i = 0; i < NW; i++) hold[i] = TO - 1;
    model_run(3);
    do_run(3, 0, '0);
    total++; if (obs_len.size() != 4) begin bad++; $display("FAIL limit_count got %0d exp 4", obs_len.size()); end
    for (int i = 0; i < 4 && i < obs_len.size(); i++) begin
      total++; if (obs_len[i] != exp_len[i] || obs_word[i] !== exp_word[i]) begin bad++; $display("FAIL limit_instr[%0d] got len=%0d w=%h exp %0d/%h", i, obs_len[i], obs_word[i], exp_len[i], exp_word[i]); end
    end
    total++; if (obs_terr !== 1'b0 || obs_fin1 !== 1'b1) begin bad++; $display("FAIL limit_status got terr=%b fin=%b exp 0/1", obs_terr, obs_fin1); end
  endtask

  task automatic test_load_start_same_cycle();
    logic [15:0] nd;
    nd = 16'($urandom) ^ mem_model[0] | 16'h0001;
    for (int i = 0; i < NW; i++) hold[i] = 1;
    do_run(0, 1, nd);
    model_run(0);
    total++; if (obs_word.size() != 1 || obs_word[0] !== nd) begin bad++; $display("FAIL load_start_bypass got n=%0d w=%h exp 1/%h", obs_word.size(), (obs_word.size() > 0) ? obs_word[0] : 16'h0, nd); end
    total++; if (obs_fin1 !== 1'b1 || obs_pc_end !== 5'd0) begin bad++; $display("FAIL load_start_end got fin=%b pc=%0d exp 1/0", obs_fin1, obs_pc_end); end
  endtask

  task automatic test_random_runs();
    int last;
    for (int r = 0; r < 6; r++) begin
      for (int j = 0; j < 4; j++) load_word(AW'($urandom), 16'($urandom));
      last = (r == 0) ? NW - 1 : (r == 1) ? 0 : int'($urandom_range(1, NW - 1));
      for (int i = 0; i < NW; i++) hold[i] = (r < 2) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 17));
      model_run(last);
      do_run(AW'(last), 0, '0);
      total++; if (obs_word.size() != exp_word.size() || obs_len.size() != exp_len.size()) begin bad++; $display("FAIL rand%0d_count got %0d/%0d exp %0d", r, obs_word.size(), obs_len.size(), exp_word.size()); end
      for (int i = 0; i < exp_word.size() && i < obs_word.size() && i < obs_len.size(); i++) begin
        total++;
        if (obs_word[i] !== exp_word[i] || obs_len[i] != exp_len[i] || obs_gap[i] != 1) begin
          bad++; $display("FAIL rand%0d_instr[%0d] got w=%h len=%0d gap=%0d exp %h/%0d/1", r, i, obs_word[i], obs_len[i], obs_gap[i], exp_word[i], exp_len[i]);
        end
      end
      total++; if (obs_terr !== exp_timeout || obs_fin1 !== !exp_timeout || obs_fin2 !== 1'b0) begin bad++; $display("FAIL rand%0d_status got terr=%b fin=%b%b exp %0d/%0d0", r, obs_terr, obs_fin1, obs_fin2, exp_timeout, !exp_timeout); end
      total++; if (obs_pc_end !== exp_pc_end || obs_unstable != 0 || obs_hang) begin bad++; $display("FAIL rand%0d_end got pc=%0d unstable=%0d hang=%0d exp %0d/0/0", r, obs_pc_end, obs_unstable, obs_hang, exp_pc_end); end
    end
  endtask

  task automatic test_reset_mid_exec();
    for (int i = 0; i < 8; i++) load_word(AW'(i), 16'($urandom));
    last_addr = 5'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    total++; if (run !== 1'b1) begin bad++; $display("FAIL midexec_running got %b exp 1", run); end
    reset = 1'b1;
    tick();
    total++; if (run !== 1'b0 || iin !== 16'h0) begin bad++; $display("FAIL midexec_reset_out got run=%b iin=%h exp 0/0000", run, iin); end
    total++; if (pc !== '0 || busy !== 1'b0) begin bad++; $display("FAIL midexec_reset_state got pc=%0d busy=%b exp 0/0", pc, busy); end
    total++; if (timeout_err !== 1'b0 || finished !== 1'b0) begin bad++; $display("FAIL midexec_reset_flags got terr=%b fin=%b exp 0/0", timeout_err, finished); end
    reset = 1'b0;
    tick();
    for (int i = 0; i < NW; i++) hold[i] = int'($urandom_range(0, 5));
    model_run(4);
    do_run(5'd4, 0, '0);
    total++; if (obs_word.size() != 5) begin bad++; $display("FAIL midexec_rerun_count got %0d exp 5", obs_word.size()); end
    for (int i = 0; i < 5 && i < obs_word.size(); i++) begin
      total++; if (obs_word[i] !== exp_word[i]) begin bad++; $display("FAIL midexec_mem[%0d] got %h exp %h", i, obs_word[i], exp_word[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; last_addr = '0; done = 1'b0;
    for (int i = 0; i < NW; i++) hold[i] = 0;
    test_reset();
    for (int i = 0; i < NW; i++) load_word(AW'(i), 16'($urandom));
    test_basic();
    test_timeout();
    test_done_at_limit();
    test_load_start_same_cycle();
    test_random_runs();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alimentador_instrucoes.md
# alimentador_instrucoes

Instruction feeder that drives the processor's 16-bit instruction input. It holds a small loadable program memory, presents one instruction at a time, holds it until the processor signals end-of-instruction, then advances. It sits upstream of the processor, as the initiator on the instruction interface whose responder is the processor core. A watchdog aborts the run if the processor never completes an instruction.

## Interface
- ADDR_WIDTH, 5, program memory address width (depth 2^ADDR_WIDTH words of 16 bits)
- TIMEOUT, 15, max EXEC cycles per instruction before abort (≥1)

- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- load_en  in  1  write load_data into memory at load_addr (honoured only in IDLE)
- load_addr  in  ADDR_WIDTH  load write address
- load_data  in  16  load write data
- start  in  1  begin program at address 0 (honoured only in IDLE)
- last_addr  in  ADDR_WIDTH  address of final instruction; sampled at start
- done  in  1  processor end-of-instruction pulse (its counter-clear condition)
- iin  out  16  instruction word to processor
- run  out  1  instruction on iin is valid; processor may execute
- pc  out  ADDR_WIDTH  address of current/next instruction
- busy  out  1  high in any state except IDLE
- finished  out  1  one-cycle pulse after last instruction completes
- timeout_err  out  1  sticky watchdog abort flag

## Operation
- States: IDLE, FETCH, EXEC.
- IDLE: run=0, iin=0. load_en writes memory. start: pc←0, last latched←last_addr, timeout_err←0, → FETCH.
- FETCH: synchronous memory read of mem[pc]; → EXEC; iin loaded with read data on that edge; timer←1.
- EXEC: run=1, iin held stable. Each cycle:
  - done=1 and pc==latched last → IDLE, finished pulses next cycle, iin←0, pc unchanged.
  - done=1 otherwise → pc←pc+1 (mod 2^ADDR_WIDTH), → FETCH.
  - done=0 and timer==TIMEOUT → timeout_err←1, → IDLE, iin←0.
  - done=0 otherwise → timer←timer+1.
- done wins over timeout in the same cycle.
- done outside EXEC ignored; start/load_en outside IDLE ignored (memory unchanged).
- load_en and start in the same IDLE cycle: write takes effect; a FETCH of that address next cycle returns the new data.
- pc wraps past 2^ADDR_WIDTH−1 to 0; run terminates only on latched last or timeout.
- last_addr changes during a run have no effect.
- Reset (any state, including mid-EXEC): state=IDLE, iin=0, run=0, pc=0, busy=0, finished=0, timeout_err=0, timer=0. Memory contents not cleared.

## Timing
- start at cycle t → FETCH at t+1 → EXEC at t+2 (iin valid, run=1).
- done sampled in EXEC at cycle c → FETCH at c+1 (run=0 one bubble) → next EXEC at c+2.
- Final done at cycle c → IDLE at c+1 with finished=1 for cycle c+1 only.
- Timeout: run=1 for exactly TIMEOUT cycles, then IDLE with timeout_err=1 from next cycle.
- All outputs registered; no combinational path from inputs to outputs.
- Timer width: clog2(TIMEOUT+1) bits.

## Structure
- Shared package: state enum (IDLE, FETCH, EXEC), INSTR_WIDTH=16 constant.
- Sub-module memoria_instrucoes: 2^ADDR_WIDTH×16 RAM, one synchronous write port, one synchronous read port, write-before-read on same address.
- Top holds FSM, pc, latched last, timer, output registers.

## Test plan
- Load 3 words 0x1234, 0x5678, 0x9ABC at 0..2, last_addr=2, start; done after 3 EXEC cycles each → iin shows the three words in order, run low one cycle between, finished pulses once, busy drops.
- start at t → iin=0x1234, run=1 exactly at t+2; done at c → FETCH with run=0 at c+1, next word at c+2.
- TIMEOUT=15, never assert done → run high 15 cycles, then IDLE, timeout_err=1, iin=0; new start clears timeout_err.
- done on the 15th EXEC cycle → no timeout; advance normally.
- ADDR_WIDTH=2, last_addr=1, start with pc path forced by load; verify wrap 3→0 when last_addr=1 reached after wrap (start, last=1 runs 0,1 only); load_en during busy → memory unchanged after run.
- Reset asserted mid-EXEC → next cycle run=0, iin=0, pc=0, busy=0; memory contents still readable by a new run.
